board_lock: RTL and testbench

Commits a landed tetromino into the 10x20 playfield bitmap, then clears completed rows with a row-serial scan/shift engine. Sits directly downstream of the shadow generator and piece controller. On a hard drop it takes the shadow coordinates; on a gravity lock it takes the control coordinates. Its `board_out` is the `boardMemory` bus consumed by the shadow generator, the collision logic and the renderer.

---
 rtl/board_lock.sv | 157 +++++++++++++++
 tb/tb_board_lock.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_lock.sv
// ============================================================================
//  Module   : board_lock
//  Purpose  : Commits a landed tetromino into the playfield bitmap, then
//             clears completed rows with a row-serial scan/shift engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module board_lock #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lock_req,
    input  logic                      clear_board,
    input  logic [9:0]                lockX1,
    input  logic [9:0]                lockX2,
    input  logic [9:0]                lockX3,
    input  logic [9:0]                lockX4,
    input  logic [9:0]                lockY1,
    input  logic [9:0]                lockY2,
    input  logic [9:0]                lockY3,
    input  logic [9:0]                lockY4,
    output logic [0:WIDTH*HEIGHT-1]   board_out,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                lines_cleared,
    output logic [9:0]                total_lines,
    output logic                      top_out
);

    localparam int         c_cells    = WIDTH * HEIGHT;
    localparam logic [4:0] c_last_row = 5'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             row_q, row_d;
    logic [0:c_cells-1]     board_q, board_d;
    logic [2:0]             lines_q, lines_d;
    logic [9:0]             total_q, total_d;
    logic                   top_q, top_d;

    logic [0:c_cells-1]     w_lock_mask;
    logic [HEIGHT-1:0]      w_row_full;
    logic                   w_cur_full;

    // Matching on decoded coordinates means out-of-range cells never hit.
    function automatic logic cell_hit(input logic [9:0] x, input logic [9:0] y,
                                      input int idx);
        return (x == 10'(idx % WIDTH)) && (y == 10'(idx / WIDTH));
    endfunction

    always_comb begin
        w_lock_mask = '0;
        for (int i = 0; i < c_cells; i++) begin
            w_lock_mask[i] = cell_hit(lockX1, lockY1, i) || cell_hit(lockX2, lockY2, i) ||
                             cell_hit(lockX3, lockY3, i) || cell_hit(lockX4, lockY4, i);
        end
    end

    generate
        for (genvar r = 0; r < HEIGHT; r++) begin : g_row_full
            assign w_row_full[r] = &board_q[r*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_cur_full = w_row_full[row_q];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        board_d = board_q;
        lines_d = lines_q;
        total_d = total_q;
        top_d   = top_q;
        case (state_q)
            S_IDLE: begin
                if (clear_board) begin
                    board_d = '0;
                    total_d = '0;
                    top_d   = 1'b0;
                end else if (lock_req) begin
                    board_d = board_q | w_lock_mask;
                    if (|(board_q & w_lock_mask)) begin
                        top_d = 1'b1;
                    end
                    lines_d = '0;
                    row_d   = c_last_row;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_cur_full) begin
                    state_d = S_SHIFT;
                end else if (row_q == 5'd0) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q - 5'd1;
                end
            end
            S_SHIFT: begin
                // Rows above the cleared one drop by one; row 0 refills empty.
                for (int r = 0; r < HEIGHT; r++) begin
                    if (r == 0) begin
                        board_d[0 +: WIDTH] = '0;
                    end else if (5'(r) <= row_q) begin
                        board_d[r*WIDTH +: WIDTH] = board_q[(r-1)*WIDTH +: WIDTH];
                    end
                end
                lines_d = (lines_q == 3'd7)     ? lines_q : lines_q + 3'd1;
                total_d = (total_q == 10'd1023) ? total_q : total_q + 10'd1;
                state_d = S_SCAN;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= c_last_row;
            board_q <= '0;
            lines_q <= '0;
            total_q <= '0;
            top_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            board_q <= board_d;
            lines_q <= lines_d;
            total_q <= total_d;
            top_q   <= top_d;
        end
    end

    assign board_out     = board_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;
    assign top_out       = top_q;

endmodule

`default_nettype wire

// File: tb/tb_board_lock.sv
// ============================================================================
//  Module   : tb_board_lock
//  Purpose  : Self-checking bench for board_lock using a playfield model
//             and a scoreboard of expected lock results.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_board_lock;

    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;

    logic           clk = 1'b0;
    logic           rst;
    logic           lock_req;
    logic           clear_board;
    logic [9:0]     lockX1, lockX2, lockX3, lockX4;
    logic [9:0]     lockY1, lockY2, lockY3, lockY4;
    logic [0:N-1]   board_out;
    logic           busy;
    logic           done;
    logic [2:0]     lines_cleared;
    logic [9:0]     total_lines;
    logic           top_out;

    board_lock #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .lock_req(lock_req), .clear_board(clear_board),
        .lockX1(lockX1), .lockX2(lockX2), .lockX3(lockX3), .lockX4(lockX4),
        .lockY1(lockY1), .lockY2(lockY2), .lockY3(lockY3), .lockY4(lockY4),
        .board_out(board_out), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines), .top_out(top_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit m_board [H][W];
    int m_total;
    int m_lc;
    bit m_top;

    typedef struct {
        logic [0:N-1] vis;
        logic [0:N-1] fin;
        int           lc;
        int           total;
        bit           top;
        int           lat;
    } exp_t;

    exp_t sb[$];

    function automatic logic [0:N-1] model_vec();
        logic [0:N-1] v;
        v = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                v[y*W+x] = m_board[y][x];
        return v;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                m_board[y][x] = 1'b0;
        m_total = 0;
        m_lc    = 0;
        m_top   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cells(input int x1, y1, x2, y2, x3, y3, x4, y4);
        lockX1 = 10'(x1); lockY1 = 10'(y1);
        lockX2 = 10'(x2); lockY2 = 10'(y2);
        lockX3 = 10'(x3); lockY3 = 10'(y3);
        lockX4 = 10'(x4); lockY4 = 10'(y4);
    endtask

    // Lock one piece; inject>0 fires a lock_req at that busy cycle and a
    // clear_board one cycle later, both of which must be ignored.
    task automatic do_lock(input string nm, input int x1, y1, x2, y2, x3, y3, x4, y4,
                           input int inject);
        int   xs[4];
        int   ys[4];
        bit   pre [H][W];
        bit   nb  [H][W];
        int   k;
        int   dst;
        bit   full;
        int   cycles;
        exp_t e;
        exp_t got;

        xs[0] = x1; xs[1] = x2; xs[2] = x3; xs[3] = x4;
        ys[0] = y1; ys[1] = y2; ys[2] = y3; ys[3] = y4;
        pre = m_board;
        for (int i = 0; i < 4; i++) begin
            if (xs[i] >= 0 && xs[i] < W && ys[i] >= 0 && ys[i] < H) begin
                if (pre[ys[i]][xs[i]]) m_top = 1'b1;
                m_board[ys[i]][xs[i]] = 1'b1;
            end
        end
        e.vis = model_vec();
        k   = 0;
        dst = H - 1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                nb[y][x] = 1'b0;
        for (int y = H - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < W; x++) full &= m_board[y][x];
            if (full) k++;
            else begin
                for (int x = 0; x < W; x++) nb[dst][x] = m_board[y][x];
                dst--;
            end
        end
        m_board = nb;
        m_lc    = (k > 7) ? 7 : k;
        m_total = (m_total + k > 1023) ? 1023 : m_total + k;
        e.fin   = model_vec();
        e.lc    = m_lc;
        e.total = m_total;
        e.top   = m_top;
        e.lat   = H + 2*k + 1;
        sb.push_back(e);

        drive_cells(x1, y1, x2, y2, x3, y3, x4, y4);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;

        got = sb.pop_front();
        checks++;
        if (board_out !== got.vis) begin
            errors++;
            $display("FAIL %s board_at_accept: got %h want %h", nm, board_out, got.vis);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", nm, busy);
        end

        cycles = 1;
        while (done !== 1'b1 && cycles < 100) begin
            if (inject > 0 && cycles == inject) begin
                drive_cells(0, 0, 1, 0, 2, 0, 3, 0);
                lock_req = 1'b1;
                tick();
                lock_req    = 1'b0;
                clear_board = 1'b1;
                tick();
                clear_board = 1'b0;
                cycles += 2;
            end else begin
                tick();
                cycles++;
            end
        end

        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: got done=%b after %0d cycles want 1", nm, done, cycles);
        end else begin
            checks++;
            if (cycles != got.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", nm, cycles, got.lat);
            end
            checks++;
            if (lines_cleared !== 3'(got.lc)) begin
                errors++;
                $display("FAIL %s lines_cleared: got %0d want %0d", nm, lines_cleared, got.lc);
            end
            checks++;
            if (board_out !== got.fin) begin
                errors++;
                $display("FAIL %s board_final: got %h want %h", nm, board_out, got.fin);
            end
            checks++;
            if (total_lines !== 10'(got.total)) begin
                errors++;
                $display("FAIL %s total_lines: got %0d want %0d", nm, total_lines, got.total);
            end
            checks++;
            if (top_out !== got.top) begin
                errors++;
                $display("FAIL %s top_out: got %b want %b", nm, top_out, got.top);
            end
        end

        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || lines_cleared !== 3'(got.lc)) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b lc=%0d want 0 0 %0d",
                     nm, done, busy, lines_cleared, got.lc);
        end
    endtask

    task automatic do_clear(input string nm, input bit with_lock);
        drive_cells(0, 0, 1, 1, 2, 2, 3, 3);
        clear_board = 1'b1;
        lock_req    = with_lock;
        tick();
        clear_board = 1'b0;
        lock_req    = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                m_board[y][x] = 1'b0;
        m_total = 0;
        m_top   = 1'b0;
        checks++;
        if (board_out !== '0 || busy !== 1'b0 || total_lines !== 10'd0 || top_out !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: got board=%h busy=%b total=%0d top=%b want all zero",
                     nm, board_out, busy, total_lines, top_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || board_out !== '0) begin
            errors++;
            $display("FAIL %s clear_settled: got busy=%b board=%h want 0", nm, busy, board_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lock_req = 1'b0;
        clear_board = 1'b0;
        drive_cells(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (board_out !== '0 || busy !== 1'b0 || done !== 1'b0 || lines_cleared !== 3'd0 ||
            total_lines !== 10'd0 || top_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got board=%h busy=%b done=%b lc=%0d total=%0d top=%b want zeros",
                     board_out, busy, done, lines_cleared, total_lines, top_out);
        end
    endtask

    task automatic test_o_piece();
        logic [0:N-1] want;
        do_lock("o_piece", 4, 18, 5, 18, 4, 19, 5, 19, 0);
        want = '0;
        want[18*W+4] = 1'b1; want[18*W+5] = 1'b1;
        want[19*W+4] = 1'b1; want[19*W+5] = 1'b1;
        checks++;
        if (board_out !== want) begin
            errors++;
            $display("FAIL o_piece_bits: got %h want %h", board_out, want);
        end
        do_clear("o_piece", 1'b0);
    endtask

    task automatic test_tetris();
        for (int c = 0; c < W - 1; c++)
            do_lock("tetris_preload", c, 16, c, 17, c, 18, c, 19, 0);
        do_lock("tetris", 9, 16, 9, 17, 9, 18, 9, 19, 0);
        checks++;
        if (board_out !== '0 || lines_cleared !== 3'd4 || total_lines !== 10'd4) begin
            errors++;
            $display("FAIL tetris_result: got board=%h lc=%0d total=%0d want 0 4 4",
                     board_out, lines_cleared, total_lines);
        end
    endtask

    task automatic test_nonadjacent();
        logic [0:N-1] want;
        do_lock("nonadj_a", 1, 19, 2, 19, 3, 19, 4, 19, 0);
        do_lock("nonadj_b", 5, 19, 6, 19, 7, 19, 8, 19, 0);
        do_lock("nonadj_c", 9, 19, 9, 17, 3, 16, 1, 17, 0);
        do_lock("nonadj_d", 2, 17, 3, 17, 4, 17, 5, 17, 0);
        do_lock("nonadj_dup", 6, 17, 7, 17, 8, 17, 8, 17, 0);
        do_lock("nonadj", 0, 19, 0, 17, 0, 18, 1, 18, 0);
        want = '0;
        want[19*W+0] = 1'b1; want[19*W+1] = 1'b1; want[18*W+3] = 1'b1;
        checks++;
        if (board_out !== want || lines_cleared !== 3'd2 || top_out !== 1'b0) begin
            errors++;
            $display("FAIL nonadj_result: got board=%h lc=%0d top=%b want %h 2 0",
                     board_out, lines_cleared, top_out, want);
        end
    endtask

    task automatic test_overlap();
        do_clear("overlap_pre", 1'b0);
        do_lock("overlap_base", 2, 10, 3, 10, 2, 11, 3, 11, 0);
        do_lock("overlap_hit", 2, 10, 2, 9, 2, 8, 2, 7, 0);
        checks++;
        if (top_out !== 1'b1) begin
            errors++;
            $display("FAIL overlap_top_set: got %b want 1", top_out);
        end
        do_lock("overlap_clean_oor", 7, 0, 12, 3, 7, 25, 1023, 1023, 0);
        checks++;
        if (top_out !== 1'b1) begin
            errors++;
            $display("FAIL overlap_top_sticky: got %b want 1", top_out);
        end
        do_clear("overlap_clear", 1'b0);
    endtask

    task automatic test_contention();
        logic [0:N-1] snap;
        do_lock("busy_ignore", 4, 5, 5, 5, 6, 5, 5, 6, 6);
        snap = board_out;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || board_out !== snap) begin
                errors++;
                $display("FAIL busy_no_extra_done: got done=%b busy=%b at idle cycle %0d want 0 0",
                         done, busy, i);
            end
        end
        do_clear("lock_and_clear", 1'b1);
    endtask

    task automatic test_rst_shift();
        do_lock("rst_pre_a", 0, 19, 1, 19, 2, 19, 3, 19, 0);
        do_lock("rst_pre_b", 4, 19, 5, 19, 6, 19, 7, 19, 0);
        do_lock("rst_pre_c", 8, 19, 8, 18, 8, 17, 8, 16, 0);
        drive_cells(9, 19, 9, 18, 9, 17, 9, 16);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        tick();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (board_out !== '0 || busy !== 1'b0 || done !== 1'b0 || lines_cleared !== 3'd0 ||
            total_lines !== 10'd0 || top_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_shift: got board=%h busy=%b done=%b lc=%0d total=%0d top=%b want zeros",
                     board_out, busy, done, lines_cleared, total_lines, top_out);
        end
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (board_out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got board=%h busy=%b want 0 0", board_out, busy);
        end
        do_lock("post_rst", 0, 0, 1, 0, 0, 1, 1, 1, 0);
    endtask

    initial begin
        test_reset();
        test_o_piece();
        test_tetris();
        test_nonadjacent();
        test_overlap();
        test_contention();
        test_rst_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
